// File: rtl/swd_target_phy_if.sv
// SWD pin pair plus the parallel request/response/write-data handshake of swd_target_phy.
// The PHY connects through 'slave'; the SWD host and register backend through 'master'.
interface swd_target_phy_if;
    logic        swdclk;
    logic        swdin;
    logic        swdout;
    logic        swdoe;
    logic        req_valid;
    logic        req_apndp;
    logic        req_rnw;
    logic [1:0]  req_addr;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_perr;
    logic        line_reset;
    logic        proto_err;

    modport master (
        output swdclk, swdin, rsp_valid, rsp_ack, rsp_rdata,
        input  swdout, swdoe, req_valid, req_apndp, req_rnw, req_addr,
        input  wr_valid, wr_data, wr_perr, line_reset, proto_err
    );

    modport slave (
        input  swdclk, swdin, rsp_valid, rsp_ack, rsp_rdata,
        output swdout, swdoe, req_valid, req_apndp, req_rnw, req_addr,
        output wr_valid, wr_data, wr_perr, line_reset, proto_err
    );
endinterface

// File: rtl/swd_target_phy.sv
// SWD target PHY: oversamples SWDCLK/SWDIO, decodes line reset and requests, returns ACK,
// shifts read data out and captures write data, with a parallel backend handshake.
module swd_target_phy #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned LresetOnes = 50
) (
    input  logic            clk_i,
    input  logic            rst_i,
    swd_target_phy_if.slave bus_io
);
    localparam int unsigned OnesW   = $clog2(LresetOnes + 1);
    localparam logic [2:0]  AckOk   = 3'b001;
    localparam logic [2:0]  AckWait = 3'b010;

    typedef enum logic [2:0] {
        StLocked, StIdle, StReq, StAck, StRdata, StWtrn, StWdata, StRtrn
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] clk_sync_q, din_sync_q;
    logic                  clk_prev_q;
    logic [5:0]            cnt_q, cnt_d;
    logic [OnesW-1:0]      ones_q, ones_d;
    logic [31:0]           data_q, data_d;
    logic                  par_q, par_d;
    logic [2:0]            ack_q, ack_d;
    logic                  oe_q, oe_d, out_q, out_d;
    logic                  req_valid_q, req_valid_d, proto_err_q, proto_err_d;
    logic                  line_reset_q, line_reset_d, wr_valid_q, wr_valid_d;
    logic                  wr_perr_q, wr_perr_d;
    logic                  req_apndp_q, req_apndp_d, req_rnw_q, req_rnw_d;
    logic [1:0]            req_addr_q, req_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;

    logic       swclk_s, din_s, sw_edge, lreset_hit, req_ok;
    logic [5:0] bit_idx;

    assign swclk_s    = clk_sync_q[SyncStages-1];
    assign din_s      = din_sync_q[SyncStages-1];
    assign sw_edge    = swclk_s & ~clk_prev_q;
    assign bit_idx    = cnt_q + 6'd1;
    assign lreset_hit = sw_edge & din_s & (ones_q == OnesW'(LresetOnes - 1));
    // Request bits 2..6 fold into par_q; data_q[31] holds the stop bit, din_s is park.
    assign req_ok     = ~par_q & ~data_q[31] & din_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLocked;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_edge) begin
            unique case (state_q)
                StLocked: state_d = StLocked;
                StIdle:   if (din_s) state_d = StReq;
                StReq:    if (bit_idx == 6'd8) state_d = req_ok ? StAck : StIdle;
                StAck: begin
                    if (bit_idx == 6'd11) begin
                        if (ack_q == AckOk) state_d = req_rnw_q ? StRdata : StWtrn;
                        else                state_d = StRtrn;
                    end
                end
                StRdata:  if (bit_idx == 6'd44) state_d = StRtrn;
                StRtrn:   state_d = StIdle;
                StWtrn:   state_d = StWdata;
                StWdata:  if (bit_idx == 6'd45) state_d = StIdle;
                default:  state_d = StLocked;
            endcase
            if (lreset_hit) state_d = StIdle;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        ones_d       = ones_q;
        data_d       = data_q;
        par_d        = par_q;
        ack_d        = ack_q;
        oe_d         = oe_q;
        out_d        = out_q;
        req_valid_d  = 1'b0;
        proto_err_d  = 1'b0;
        line_reset_d = 1'b0;
        wr_valid_d   = 1'b0;
        wr_perr_d    = wr_perr_q;
        wr_data_d    = wr_data_q;
        req_apndp_d  = req_apndp_q;
        req_rnw_d    = req_rnw_q;
        req_addr_d   = req_addr_q;
        if (sw_edge) begin
            if (!din_s)                                 ones_d = '0;
            else if (ones_q != OnesW'(LresetOnes))      ones_d = ones_q + 1'b1;
            unique case (state_q)
                StLocked: cnt_d = '0;
                StIdle: begin
                    cnt_d = {5'd0, din_s};
                    par_d = 1'b0;
                end
                StReq: begin
                    cnt_d = bit_idx;
                    if (bit_idx <= 6'd7) data_d = {din_s, data_q[31:1]};
                    if (bit_idx <= 6'd6) par_d = par_q ^ din_s;
                    if (bit_idx == 6'd8) begin
                        if (req_ok) begin
                            req_valid_d = 1'b1;
                            req_apndp_d = data_q[26];
                            req_rnw_d   = data_q[27];
                            req_addr_d  = data_q[29:28];
                        end else begin
                            proto_err_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end
                end
                StAck: begin
                    cnt_d = bit_idx;
                    oe_d  = 1'b1;
                    par_d = 1'b0;
                    if (bit_idx == 6'd9) begin
                        // Backend gets exactly one SWDCLK period; no response yet means WAIT.
                        ack_d  = bus_io.rsp_valid ? bus_io.rsp_ack : AckWait;
                        data_d = bus_io.rsp_rdata;
                        out_d  = ack_d[0];
                    end else if (bit_idx == 6'd10) begin
                        out_d = ack_q[1];
                    end else begin
                        out_d = ack_q[2];
                    end
                end
                StRdata: begin
                    cnt_d = bit_idx;
                    if (bit_idx == 6'd44) begin
                        out_d = par_q;
                    end else begin
                        out_d  = data_q[0];
                        par_d  = par_q ^ data_q[0];
                        data_d = {1'b0, data_q[31:1]};
                    end
                end
                StRtrn: begin
                    cnt_d = '0;
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                end
                StWtrn: begin
                    cnt_d = bit_idx;
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                    par_d = 1'b0;
                end
                StWdata: begin
                    if (bit_idx == 6'd45) begin
                        cnt_d      = '0;
                        wr_valid_d = 1'b1;
                        wr_data_d  = data_q;
                        wr_perr_d  = par_q ^ din_s;
                    end else begin
                        cnt_d  = bit_idx;
                        data_d = {din_s, data_q[31:1]};
                        par_d  = par_q ^ din_s;
                    end
                end
                default: cnt_d = '0;
            endcase
            // A completed line reset aborts whatever was in flight, including a pending write.
            if (lreset_hit) begin
                line_reset_d = 1'b1;
                oe_d         = 1'b0;
                out_d        = 1'b0;
                cnt_d        = '0;
                req_valid_d  = 1'b0;
                proto_err_d  = 1'b0;
                wr_valid_d   = 1'b0;
                wr_data_d    = wr_data_q;
                wr_perr_d    = wr_perr_q;
                req_apndp_d  = req_apndp_q;
                req_rnw_d    = req_rnw_q;
                req_addr_d   = req_addr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q   <= '0;
            din_sync_q   <= '0;
            clk_prev_q   <= 1'b0;
            cnt_q        <= '0;
            ones_q       <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            ack_q        <= '0;
            oe_q         <= 1'b0;
            out_q        <= 1'b0;
            req_valid_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            line_reset_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_perr_q    <= 1'b0;
            wr_data_q    <= '0;
            req_apndp_q  <= 1'b0;
            req_rnw_q    <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            clk_sync_q   <= {clk_sync_q[SyncStages-2:0], bus_io.swdclk};
            din_sync_q   <= {din_sync_q[SyncStages-2:0], bus_io.swdin};
            clk_prev_q   <= swclk_s;
            cnt_q        <= cnt_d;
            ones_q       <= ones_d;
            data_q       <= data_d;
            par_q        <= par_d;
            ack_q        <= ack_d;
            oe_q         <= oe_d;
            out_q        <= out_d;
            req_valid_q  <= req_valid_d;
            proto_err_q  <= proto_err_d;
            line_reset_q <= line_reset_d;
            wr_valid_q   <= wr_valid_d;
            wr_perr_q    <= wr_perr_d;
            wr_data_q    <= wr_data_d;
            req_apndp_q  <= req_apndp_d;
            req_rnw_q    <= req_rnw_d;
            req_addr_q   <= req_addr_d;
        end
    end

    assign bus_io.swdout     = out_q;
    assign bus_io.swdoe      = oe_q;
    assign bus_io.req_valid  = req_valid_q;
    assign bus_io.req_apndp  = req_apndp_q;
    assign bus_io.req_rnw    = req_rnw_q;
    assign bus_io.req_addr   = req_addr_q;
    assign bus_io.wr_valid   = wr_valid_q;
    assign bus_io.wr_data    = wr_data_q;
    assign bus_io.wr_perr    = wr_perr_q;
    assign bus_io.line_reset = line_reset_q;
    assign bus_io.proto_err  = proto_err_q;
endmodule

// File: doc/swd_target_phy.md
# swd_target_phy

SWD target-side PHY: the responder end of the serial-wire link driven by the bridge's SWD host PHY. It oversamples SWDCLK/SWDIO in a single fast clock domain and decodes line resets and 8-bit request packets. It returns the 3-bit ACK, shifts out read data with parity, and captures write data with parity check. A parallel request/response handshake connects it to a DP/AP register backend; it is used as a bench model and as a soft debug-target port.

## Interface
Parameters:
- SYNC_STAGES, 2, input synchronizer depth for SWDCLK and SWDIN (≥2).
- LRESET_ONES, 50, consecutive sampled 1s that constitute a line reset.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock; must be ≥8× SWDCLK frequency.
- RESET  in  1  synchronous, active-high reset.
- SWDCLK  in  1  async SWD clock from host.
- SWDIN  in  1  async SWDIO input.
- SWDOUT  out  1  SWDIO output data.
- SWDOE  out  1  SWDIO output enable (1 = target drives).
- REQ_VALID  out  1  one-CLK pulse: valid request decoded.
- REQ_APNDP  out  1  request APnDP bit.
- REQ_RNW  out  1  request RnW bit.
- REQ_ADDR  out  2  request A[3:2].
- RSP_VALID  in  1  backend response ready; level, sampled at ACK decision.
- RSP_ACK  in  3  ACK code, LSB sent first (OK=3'b001, WAIT=3'b010, FAULT=3'b100).
- RSP_RDATA  in  32  read data, LSB first.
- WR_VALID  out  1  one-CLK pulse: write data phase complete.
- WR_DATA  out  32  captured write data.
- WR_PERR  out  1  write parity error, valid with WR_VALID.
- LINE_RESET  out  1  one-CLK pulse when the line-reset count is reached.
- PROTO_ERR  out  1  one-CLK pulse on a malformed request.

## Operation
- SWDCLK and SWDIN pass through SYNC_STAGES flops. A rising edge ("edge") is synced SWDCLK 1 with the previous synced value 0. All protocol actions occur on the edge CLK cycle.
- Ones counter: increments on each edge with SWDIN=1 and saturates at LRESET_ONES; cleared on an edge with SWDIN=0. Reaching LRESET_ONES pulses LINE_RESET once and forces state IDLE with SWDOE=0, from any state.
- States: LOCKED (after RESET, ignores everything until a line reset), IDLE, REQ, ACK, RDATA, WTRN, WDATA, RTRN.
- IDLE: an edge sampling 1 is the start bit and moves to REQ with bit index 1. Idle 0s are ignored.
- REQ: samples APnDP, RnW, A2, A3, parity, stop, park on edges 2–8.
  - Valid only if parity equals XOR of bits 2–5, stop=0 and park=1. Valid requests pulse REQ_VALID on edge 8 with the fields held stable until the next request.
  - Invalid: pulse PROTO_ERR, return to IDLE, never drive.
- ACK, edge 9 (turnaround):
  - Latch ack = RSP_VALID ? RSP_ACK : 3'b010. Also latch RSP_RDATA.
  - Set SWDOE=1 and SWDOUT=ack[0]. Edges 10 and 11 drive ack[1] and ack[2].
- After edge 11:
  - ack==OK and RnW=1 → RDATA.
  - ack==OK and RnW=0 → WTRN.
  - Otherwise SWDOE=0 on edge 12, then IDLE.
- RDATA: edges 12–43 drive data[0..31], edge 44 drives even parity (XOR of data), edge 45 sets SWDOE=0 (RTRN), then IDLE.
- WTRN: edge 12 sets SWDOE=0. WDATA samples data on edges 13–44 and parity on edge 45.
  - Edge 45 pulses WR_VALID, updates WR_DATA and sets WR_PERR = parity mismatch, then IDLE.
- Bit counter is 6 bits. Parity accumulates in a 1-bit XOR register cleared at each phase start.

## Timing
- Reset values: SWDOUT=0, SWDOE=0, all pulses 0, REQ_* = 0, WR_DATA=0, WR_PERR=0, state LOCKED, counters 0.
- Pin-to-action latency: SWDOUT/SWDOE change SYNC_STAGES+1 CLK after the SWDCLK pin rises. Driven values are held a full SWDCLK period.
- Backend window: REQ_VALID to ACK decision is exactly one SWDCLK period. A late RSP_VALID gives WAIT, never a partial response.
- A line reset during RDATA or WDATA aborts immediately: SWDOE=0 in the same CLK, no WR_VALID.
- RESET mid-transfer: next CLK returns to reset values.

## Test plan
- Reset, 50 ones, 2 zeros → LINE_RESET pulses once; a subsequent request is accepted. A request sent without the line reset gets no response (SWDOE stays 0).
- Read DP addr 0 (request 8'hA5 LSB first), RSP_VALID=1, ACK=001, RDATA=32'h2BA01477:
  - ACK bits 1,0,0 on edges 9–11.
  - Data LSB first on edges 12–43, parity=0 on edge 44.
  - SWDOE=0 at edge 45.
- Write AP addr 4, data 32'hDEADBEEF with correct parity → WR_VALID, WR_DATA=32'hDEADBEEF, WR_PERR=0. Repeat with flipped parity → WR_PERR=1.
- RSP_VALID=0 at edge 9 → ACK 0,1,0 (WAIT), SWDOE=0 at edge 12, no data phase. RSP_ACK=100 → FAULT, same behaviour.
- Request with bad parity, and separately stop=1 → PROTO_ERR pulse, no REQ_VALID, SWDOE never asserted.
- 50 ones injected mid-read at data bit 10 → SWDOE drops, LINE_RESET pulses; the next read completes normally.
